// File: rtl/save_pkg.sv
// Shared types and helpers for the save-key sequence detector.
package save_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RELEASE = 2'd2
    } save_state_t;

    // Parity flag for a saved code: odd=1 flags an odd count of ones,
    // odd=0 flags an even count of ones.
    function automatic logic parity_f(input logic [63:0] code, input logic odd);
        logic ones;
        ones = ^code;
        return odd ? ones : ~ones;
    endfunction

endpackage

// File: rtl/esc_edge_det.sv
// Registers the escape lines and derives per-bit rising and falling edges.
module esc_edge_det #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] esc,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] esc_q;

    // Previous-cycle copy of the escape lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            esc_q <= '0;
        end else begin
            esc_q <= esc;
        end
    end

    assign rise = esc & ~esc_q;
    assign fall = ~esc & esc_q;

endmodule

// File: rtl/save_seq_detector.sv
// Detects the ordered escape sequence ESC[0] -> ... -> ESC[NUM_ESC-1] while
// the input code stays stable, then latches the code and its parity flag.
module save_seq_detector
    import save_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_ESC    = 3,
    parameter int TIMEOUT    = 16,
    parameter bit ODD_PARITY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   inp,
    input  logic [NUM_ESC-1:0] ESC,
    output logic [WIDTH-1:0]   save_out,
    output logic               YP,
    output logic               YC,
    output logic               err,
    output logic               busy
);

    localparam int IDX_W   = $clog2(NUM_ESC + 1);
    localparam int TIMER_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_ESC - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);
    localparam logic [NUM_ESC-1:0] ONE_HOT0  = NUM_ESC'(1);
    localparam logic [NUM_ESC-1:0] ALL_ONES  = {NUM_ESC{1'b1}};
    localparam logic               YP_RESET  = ODD_PARITY ? 1'b0 : 1'b1;

    save_state_t        state;
    logic [IDX_W-1:0]   idx;
    logic [TIMER_W-1:0] timer;
    logic [WIDTH-1:0]   cand;

    logic [NUM_ESC-1:0] rise;
    logic [NUM_ESC-1:0] fall;
    logic [NUM_ESC-1:0] want;
    logic [NUM_ESC-1:0] held;
    logic               wrong_rise;
    logic               code_changed;
    logic               early_release;

    esc_edge_det #(.N(NUM_ESC)) u_edge (
        .clk  (clk),
        .rst  (rst),
        .esc  (ESC),
        .rise (rise),
        .fall (fall)
    );

    // The next expected key is bit idx; keys below idx must remain pressed.
    assign want          = ONE_HOT0 << idx;
    assign held          = ~(ALL_ONES << idx);
    assign wrong_rise    = (rise != '0) && (rise != want);
    assign code_changed  = (inp != cand);
    assign early_release = |(fall & held);

    // Sequence FSM with timer, candidate capture and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            timer    <= '0;
            cand     <= '0;
            save_out <= '0;
            YP       <= YP_RESET;
            YC       <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            YC  <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise == ONE_HOT0) begin
                        cand  <= inp;
                        idx   <= IDX_W'(1);
                        timer <= '0;
                        state <= COLLECT;
                        busy  <= 1'b1;
                    end else if (rise != '0) begin
                        err <= 1'b1;
                    end
                end
                COLLECT: begin
                    // Abort priority: wrong rise, code change, early release, timeout.
                    if (wrong_rise || code_changed || early_release) begin
                        err   <= 1'b1;
                        idx   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (rise == want) begin
                        timer <= '0;
                        idx   <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            save_out <= cand;
                            YP       <= parity_f(64'(cand), ODD_PARITY);
                            YC       <= 1'b1;
                            state    <= RELEASE;
                        end
                    end else if (timer == TIMER_MAX) begin
                        err   <= 1'b1;
                        idx   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                RELEASE: begin
                    if (ESC == '0) begin
                        idx   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_save_seq_detector.sv
// Directed bench for save_seq_detector (WIDTH=8, NUM_ESC=3, TIMEOUT=16, odd parity).
module tb_save_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] inp = 8'h00;
    logic [2:0] ESC = 3'b000;
    logic [7:0] save_out;
    logic       YP;
    logic       YC;
    logic       err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int yc_cnt = 0;
    int err_cnt = 0;
    int yc_base;
    int err_base;

    save_seq_detector #(
        .WIDTH(8), .NUM_ESC(3), .TIMEOUT(16), .ODD_PARITY(1)
    ) dut (
        .clk(clk), .rst(rst), .inp(inp), .ESC(ESC),
        .save_out(save_out), .YP(YP), .YC(YC), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (YC)  yc_cnt  <= yc_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #1;
        chk("rst_save", save_out, 8'h00);
        chk("rst_yp", YP, 1'b0);
        chk("rst_yc", YC, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Happy path, rises 5 cycles apart
        inp = 8'h7E;
        yc_base = yc_cnt;
        ESC = 3'b001; tick(1);
        chk("hp_busy1", busy, 1'b1);
        chk("hp_err1", err, 1'b0);
        tick(4);
        ESC = 3'b011; tick(1);
        chk("hp_yc2", YC, 1'b0);
        tick(4);
        ESC = 3'b111; tick(1);
        chk("hp_yc", YC, 1'b1);
        chk("hp_save", save_out, 8'h7E);
        chk("hp_yp", YP, 1'b0);
        tick(1);
        chk("hp_yc_off", YC, 1'b0);
        chk("hp_busy_rel", busy, 1'b1);
        ESC = 3'b000; tick(1);
        chk("hp_busy_end", busy, 1'b0);
        chk("hp_yc_once", yc_cnt - yc_base, 1);

        // Wrong order in IDLE
        inp = 8'h41;
        ESC = 3'b010; tick(1);
        chk("wo_err", err, 1'b1);
        chk("wo_busy", busy, 1'b0);
        chk("wo_save", save_out, 8'h7E);
        tick(1);
        chk("wo_err_off", err, 1'b0);
        ESC = 3'b000; tick(1);
        ESC = 3'b001; tick(1);
        ESC = 3'b011; tick(1);
        ESC = 3'b111; tick(1);
        chk("wo2_yc", YC, 1'b1);
        chk("wo2_save", save_out, 8'h41);
        chk("wo2_yp", YP, 1'b0);
        ESC = 3'b000; tick(2);

        // Timeout: err exactly 16 cycles after the first rise
        err_base = err_cnt;
        ESC = 3'b001; tick(1);
        tick(15);
        chk("to_err_early", err, 1'b0);
        chk("to_busy_early", busy, 1'b1);
        tick(1);
        chk("to_err", err, 1'b1);
        chk("to_busy", busy, 1'b0);
        ESC = 3'b011; tick(1);
        chk("to_late_yc", YC, 1'b0);
        ESC = 3'b111; tick(1);
        chk("to_late_yc2", YC, 1'b0);
        chk("to_save", save_out, 8'h41);
        ESC = 3'b000; tick(2);

        // Code change mid-sequence
        inp = 8'h5B;
        ESC = 3'b001; tick(1);
        ESC = 3'b011; tick(1);
        inp = 8'h1B; tick(1);
        chk("cc_err", err, 1'b1);
        chk("cc_busy", busy, 1'b0);
        chk("cc_save", save_out, 8'h41);
        ESC = 3'b000; tick(2);

        // Early release, then a full sequence
        err_base = err_cnt;
        ESC = 3'b001; tick(1);
        ESC = 3'b011; tick(1);
        ESC = 3'b010; tick(1);
        chk("er_err", err, 1'b1);
        ESC = 3'b000; tick(2);
        chk("er_err_once", err_cnt - err_base, 1);
        ESC = 3'b001; tick(1);
        ESC = 3'b011; tick(1);
        ESC = 3'b111; tick(1);
        chk("er_yc", YC, 1'b1);
        chk("er_err_none", err, 1'b0);
        chk("er_save", save_out, 8'h1B);
        chk("er_yp", YP, 1'b0);
        ESC = 3'b000; tick(2);

        // Out-of-order rise while collecting
        ESC = 3'b001; tick(1);
        ESC = 3'b101; tick(1);
        chk("oo_err", err, 1'b1);
        chk("oo_busy", busy, 1'b0);
        ESC = 3'b000; tick(2);

        // Reset mid-operation
        ESC = 3'b001; tick(1);
        ESC = 3'b011; tick(1);
        rst = 1'b1;
        #1;
        chk("mr_save", save_out, 8'h00);
        chk("mr_yp", YP, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_yc", YC, 1'b0);
        ESC = 3'b000;
        tick(1);
        rst = 1'b0;
        tick(1);
        ESC = 3'b111; tick(1);
        chk("mr_multi_err", err, 1'b1);
        chk("mr_multi_yc", YC, 1'b0);
        ESC = 3'b000; tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
